// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmit path (feeder and serial_write).
package serial_pkg;

  localparam int DEFAULT_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count, combinational head output and
// synchronous flush. Pushes while full are ignored here; the caller flags them.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/serial_tx_feeder.sv
// Byte queue between the USB receive parser and the UART transmitter; hands
// bytes over one at a time using save_data and the transmitter's TiP flag.
module serial_tx_feeder
  import serial_pkg::*;
#(
  parameter int DATA_BITS    = DEFAULT_DATA_BITS,
  parameter int FIFO_DEPTH   = 16,
  parameter int LOAD_TIMEOUT = 1023,
  parameter int CNT_W        = $clog2(FIFO_DEPTH+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 flush,
  output logic [DATA_BITS-1:0] tx_data,
  output logic                 save_data,
  input  logic                 tip,
  output logic [CNT_W-1:0]     fifo_count,
  output logic                 overflow,
  output logic                 tx_stall
);

  localparam int TMO_W = $clog2(LOAD_TIMEOUT+1);

  tx_state_t            state;
  tx_state_t            state_nxt;
  logic [TMO_W-1:0]     tmo_cnt;
  logic [TMO_W-1:0]     tmo_nxt;
  logic                 pop;
  logic                 stall_set;
  logic                 ovf_set;
  logic                 full;
  logic                 empty;
  logic [DATA_BITS-1:0] head;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (in_valid),
    .pop   (pop),
    .din   (in_data),
    .dout  (head),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  assign in_ready = !full;
  assign ovf_set  = in_valid && full && !flush;

  // IDLE also waits on tip so a frame still running after reset is not overrun.
  always_comb begin
    state_nxt = state;
    tmo_nxt   = tmo_cnt;
    pop       = 1'b0;
    stall_set = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !tip) begin
          pop       = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (tip) begin
          state_nxt = WAIT_DONE;
          tmo_nxt   = '0;
        end else if (tmo_cnt == TMO_W'(LOAD_TIMEOUT - 1)) begin
          stall_set = 1'b1;
          state_nxt = IDLE;
          tmo_nxt   = '0;
        end else begin
          tmo_nxt = tmo_cnt + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tip) state_nxt = GAP;
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      save_data <= 1'b0;
      tx_data   <= '0;
      overflow  <= 1'b0;
      tx_stall  <= 1'b0;
    end else begin
      state     <= state_nxt;
      tmo_cnt   <= tmo_nxt;
      save_data <= (state_nxt == LOAD);
      if (pop) tx_data <= head;
      // flush clears the sticky flags but leaves the in-flight handoff alone.
      if (flush) begin
        overflow <= 1'b0;
        tx_stall <= 1'b0;
      end else begin
        if (ovf_set)   overflow <= 1'b1;
        if (stall_set) tx_stall <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_tx_feeder.sv
// Directed bench for serial_tx_feeder with a TiP transmitter model and a
// byte scoreboard checked at every save_data rising edge.
module tb_serial_tx_feeder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       flush = 1'b0;
  logic [7:0] tx_data;
  logic       save_data;
  logic       tip;
  logic [4:0] fifo_count;
  logic       overflow;
  logic       tx_stall;

  logic       tip_model = 1'b0;
  logic       tip_hold = 1'b0;
  logic       tip_en = 1'b1;
  logic       save_q = 1'b0;
  logic       dly = 1'b0;
  int         hold = 0;

  int         errors = 0;
  int         checks = 0;
  int         frames = 0;
  int         cur_len = 0;
  int         last_len = 0;
  logic       save_prev = 1'b0;
  logic [7:0] cur_byte = 8'h00;
  logic [7:0] sb [$];

  assign tip = tip_model | tip_hold;

  serial_tx_feeder #(
    .DATA_BITS    (8),
    .FIFO_DEPTH   (16),
    .LOAD_TIMEOUT (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .flush      (flush),
    .tx_data    (tx_data),
    .save_data  (save_data),
    .tip        (tip),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .tx_stall   (tx_stall)
  );

  always #5 clk = ~clk;

  // Transmitter model: tip rises 2 cycles after save_data rises, high 20 cycles.
  always @(posedge clk) begin
    save_q <= save_data;
    if (!tip_en) begin
      tip_model <= 1'b0;
      dly       <= 1'b0;
      hold      <= 0;
    end else if (save_data && !save_q) begin
      dly <= 1'b1;
    end else if (dly) begin
      dly       <= 1'b0;
      tip_model <= 1'b1;
      hold      <= 19;
    end else if (tip_model) begin
      if (hold == 0) tip_model <= 1'b0;
      else           hold <= hold - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (save_data === 1'b1) begin
      if (!save_prev) begin
        frames++;
        cur_len  = 1;
        cur_byte = tx_data;
        check("frame_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) check("frame_byte", 32'(tx_data), 32'(sb.pop_front()));
      end else begin
        cur_len++;
        check("tx_data_stable", 32'(tx_data), 32'(cur_byte));
      end
    end else if (save_prev) begin
      last_len = cur_len;
    end
    save_prev = (save_data === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit expect_accept);
    in_data  = b;
    in_valid = 1'b1;
    if (expect_accept) sb.push_back(b);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain(input int max_cyc, input string tag);
    int stable = 0;
    int n = 0;
    while (stable < 4 && n < max_cyc) begin
      tick();
      n++;
      if (!save_data && !tip && fifo_count == 0) stable++;
      else stable = 0;
    end
    check({tag, "_drained"}, 32'(stable >= 4), 1);
    check({tag, "_sb_empty"}, 32'(sb.size()), 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"}, 32'(fifo_count), 0);
    check({tag, "_save"}, 32'(save_data), 0);
    check({tag, "_tx_data"}, 32'(tx_data), 0);
    check({tag, "_overflow"}, 32'(overflow), 0);
    check({tag, "_stall"}, 32'(tx_stall), 0);
    check({tag, "_in_ready"}, 32'(in_ready), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bit saw;

    repeat (3) tick();
    check_reset_state("rst1");
    rst = 1'b1;
    tick();

    // Single byte: count 1 then 0, three-cycle save_data pulse.
    in_data = 8'hA5; in_valid = 1'b1; sb.push_back(8'hA5);
    tick();
    in_valid = 1'b0;
    check("t1_count_push", 32'(fifo_count), 1);
    check("t1_save_early", 32'(save_data), 0);
    tick();
    check("t1_count_pop", 32'(fifo_count), 0);
    check("t1_save", 32'(save_data), 1);
    check("t1_tx_data", 32'(tx_data), 32'hA5);
    drain(80, "t1");
    check("t1_pulse_len", 32'(last_len), 3);
    check("t1_frames", 32'(frames), 1);

    // Fill the FIFO with the transmitter held busy, then overflow it.
    tip_hold = 1'b1;
    for (int i = 0; i < 16; i++) push_byte(8'(i), 1'b1);
    check("t2_count_full", 32'(fifo_count), 16);
    check("t2_in_ready_full", 32'(in_ready), 0);
    push_byte(8'hFF, 1'b0);
    check("t2_overflow", 32'(overflow), 1);
    check("t2_count_after_ovf", 32'(fifo_count), 16);
    tip_hold = 1'b0;
    drain(800, "t2");
    check("t2_frames", 32'(frames), 17);

    // Push and pop in the same cycle at count 3.
    tip_hold = 1'b1;
    push_byte(8'h11, 1'b1);
    push_byte(8'h22, 1'b1);
    push_byte(8'h33, 1'b1);
    check("t3_count3", 32'(fifo_count), 3);
    tip_hold = 1'b0;
    in_data = 8'h44; in_valid = 1'b1; sb.push_back(8'h44);
    tick();
    in_valid = 1'b0;
    check("t3_count_pushpop", 32'(fifo_count), 3);
    check("t3_save", 32'(save_data), 1);
    check("t3_tx_data", 32'(tx_data), 32'h11);
    drain(200, "t3");
    check("t3_frames", 32'(frames), 21);

    // Transmitter never answers: byte abandoned after the timeout.
    tip_en = 1'b0;
    push_byte(8'h3C, 1'b1);
    drain(60, "t4");
    check("t4_pulse_len", 32'(last_len), 8);
    check("t4_stall", 32'(tx_stall), 1);
    tip_en = 1'b1;
    push_byte(8'h5A, 1'b1);
    drain(80, "t4b");
    check("t4b_pulse_len", 32'(last_len), 3);
    check("t4b_stall_sticky", 32'(tx_stall), 1);
    check("t4_frames", 32'(frames), 23);

    // Reset while the transmitter is busy with 4 bytes queued.
    for (int i = 0; i < 5; i++) push_byte(8'hB0 + 8'(i), 1'b1);
    repeat (4) tick();
    check("t5_count4", 32'(fifo_count), 4);
    check("t5_tip_busy", 32'(tip), 1);
    rst = 1'b0;
    tick();
    check_reset_state("t5_rst");
    rst = 1'b1;
    sb.delete();
    push_byte(8'hC7, 1'b1);
    saw = 1'b0;
    n = 0;
    while (tip && n < 100) begin
      if (save_data) saw = 1'b1;
      tick();
      n++;
    end
    check("t5_no_save_while_tip", 32'(saw), 0);
    check("t5_tip_fell", 32'(tip), 0);
    drain(80, "t5");
    check("t5_frames", 32'(frames), 25);

    // Flush with a full FIFO clears overflow and tx_stall; same-cycle push dropped.
    tip_en = 1'b0;
    push_byte(8'h77, 1'b1);
    drain(60, "t6");
    check("t6_stall", 32'(tx_stall), 1);
    tip_en = 1'b1;
    tip_hold = 1'b1;
    for (int i = 0; i < 16; i++) push_byte(8'hE0 + 8'(i), 1'b1);
    push_byte(8'hFF, 1'b0);
    check("t6_overflow", 32'(overflow), 1);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h99;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    check("t6_count_flushed", 32'(fifo_count), 0);
    check("t6_overflow_clr", 32'(overflow), 0);
    check("t6_stall_clr", 32'(tx_stall), 0);
    tip_hold = 1'b0;
    repeat (5) tick();
    check("t6_no_frame", 32'(frames), 26);
    check("t6_count_idle", 32'(fifo_count), 0);

    // Flush during WAIT_DONE with 5 queued: in-flight byte completes, nothing more.
    for (int i = 0; i < 6; i++) push_byte(8'hD0 + 8'(i), 1'b1);
    repeat (4) tick();
    check("t6b_count5", 32'(fifo_count), 5);
    check("t6b_tip_busy", 32'(tip), 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    sb.delete();
    check("t6b_count_flushed", 32'(fifo_count), 0);
    check("t6b_overflow", 32'(overflow), 0);
    drain(100, "t6b");
    check("t6b_frames", 32'(frames), 27);
    check("t6b_pulse_len", 32'(last_len), 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
